// File: rtl/shift_register_8_pkg.sv
// rtl/shift_register_8_pkg.sv - shared width, mode codes and reset value for shift_register_8
package shift_register_8_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

endpackage

// File: rtl/shift_register_8_cell.sv
// rtl/shift_register_8_cell.sv - one bit-slice: 4:1 next-state mux, clear gating, one flop
module shift_register_8_cell
    import shift_register_8_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_n,
    input  logic [1:0] mode,
    input  logic       right_in,
    input  logic       left_in,
    input  logic       d,
    output logic       q
);

    logic nxt;

    always_comb begin
        nxt = q;
        case (mode)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = right_in;
            MODE_SHL:  nxt = left_in;
            MODE_LOAD: nxt = d;
            default:   nxt = q;
        endcase
    end

    // Hard reset and soft clear collapse to the same result, so one gate serves both.
    always_ff @(posedge clk) begin
        if (rst || !clr_n) begin
            q <= RST_VAL[IDX];
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/shift_register_8.sv
// rtl/shift_register_8.sv - 8-bit universal shift register; SHIFT_REG8_ROTATE_EN selects circular shifts
module shift_register_8
    import shift_register_8_pkg::*;
(
    input  logic             CP,
    input  logic             CR,
    input  logic             clr_n,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [1:0]       mode;
    logic             fb_hi;
    logic             fb_lo;
    logic [WIDTH-1:0] right_nb;
    logic [WIDTH-1:0] left_nb;

    assign mode = {S1, S0};

`ifdef SHIFT_REG8_ROTATE_EN
    assign fb_hi = Q[0];
    assign fb_lo = Q[WIDTH-1];
`else
    assign fb_hi = 1'b0;
    assign fb_lo = 1'b0;
`endif

    // Each bit sees its upper neighbour for right shifts and its lower neighbour for left shifts.
    assign right_nb = {fb_hi, Q[WIDTH-1:1]};
    assign left_nb  = {Q[WIDTH-2:0], fb_lo};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_register_8_cell #(
            .IDX(i)
        ) u_cell (
            .clk     (CP),
            .rst     (CR),
            .clr_n   (clr_n),
            .mode    (mode),
            .right_in(right_nb[i]),
            .left_in (left_nb[i]),
            .d       (D[i]),
            .q       (Q[i])
        );
    end

endmodule

// File: tb/tb_shift_register_8.sv
// tb/tb_shift_register_8.sv - scoreboard bench for shift_register_8 (either SHIFT_REG8_ROTATE_EN build)
module tb_shift_register_8;

    logic       CP = 1'b0;
    logic       CR;
    logic       clr_n;
    logic       S1;
    logic       S0;
    logic [7:0] D;
    logic [7:0] Q;

    logic [7:0] exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

`ifdef SHIFT_REG8_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    shift_register_8 dut (
        .CP   (CP),
        .CR   (CR),
        .clr_n(clr_n),
        .S1   (S1),
        .S0   (S0),
        .D    (D),
        .Q    (Q)
    );

    always #5 CP = ~CP;

    task automatic drive(input logic cr, input logic cn, input logic [1:0] s, input logic [7:0] d);
        CR    = cr;
        clr_n = cn;
        {S1, S0} = s;
        D     = d;
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        drive(1'b1, 1'b1, 2'b11, 8'hA5);
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL reset: Q=%h expected %h", Q, e);
        end
        drive(1'b0, 1'b1, 2'b11, 8'hA5);
        exp_q.push_back(8'hA5);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL reset_release_load: Q=%h expected %h", Q, e);
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] e;
        logic [7:0] start;
        start = ROT ? 8'h80 : 8'h81;
        drive(1'b0, 1'b1, 2'b11, start);
        exp_q.push_back(start);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (ROT) exp_q.push_back(8'h40 >> i | ((i == 7) ? 8'h80 : 8'h00));
            else     exp_q.push_back(8'h40 >> i);
        end
        drive(1'b0, 1'b1, 2'b01, 8'h00);
        void'(exp_q.pop_front());
        tests_run++;
        if (Q !== start) begin
            tests_failed++;
            $display("FAIL shr_load: Q=%h expected %h", Q, start);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (Q !== e) begin
                tests_failed++;
                $display("FAIL shr_step%0d: Q=%h expected %h", i, Q, e);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [7:0] e;
        drive(1'b0, 1'b1, 2'b11, 8'h01);
        tick();
        tests_run++;
        if (Q !== 8'h01) begin
            tests_failed++;
            $display("FAIL shl_load: Q=%h expected 01", Q);
        end
        for (int i = 1; i <= 9; i++) begin
            if (i <= 7)      exp_q.push_back(8'h01 << i);
            else if (i == 8) exp_q.push_back(ROT ? 8'h01 : 8'h00);
            else             exp_q.push_back(ROT ? 8'h02 : 8'h00);
        end
        drive(1'b0, 1'b1, 2'b10, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (Q !== e) begin
                tests_failed++;
                $display("FAIL shl_step%0d: Q=%h expected %h", i, Q, e);
            end
        end
    endtask

    task automatic test_hold_clear();
        logic [7:0] e;
        drive(1'b0, 1'b1, 2'b11, 8'h3C);
        tick();
        drive(1'b0, 1'b1, 2'b00, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h3C);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (Q !== e) begin
                tests_failed++;
                $display("FAIL hold%0d: Q=%h expected %h", i, Q, e);
            end
        end
        // A load requested mid-cycle but withdrawn before the edge must not happen.
        drive(1'b0, 1'b1, 2'b11, 8'h55);
        #2;
        drive(1'b0, 1'b1, 2'b00, 8'h55);
        exp_q.push_back(8'h3C);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL mid_cycle_mode: Q=%h expected %h", Q, e);
        end
        drive(1'b0, 1'b0, 2'b01, 8'hFF);
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL soft_clear: Q=%h expected %h", Q, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 2'b00 : ((i == 1) ? 2'b01 : 2'b10), 8'hFF);
            exp_q.push_back(8'h00);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (Q !== e) begin
                tests_failed++;
                $display("FAIL zero_stays%0d: Q=%h expected %h", i, Q, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] e;
        drive(1'b0, 1'b1, 2'b11, 8'h5A);
        tick();
        drive(1'b1, 1'b0, 2'b11, 8'hFF);
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL prio_cr_clr: Q=%h expected %h", Q, e);
        end
        drive(1'b0, 1'b0, 2'b11, 8'hFF);
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL prio_clr_over_load: Q=%h expected %h", Q, e);
        end
        drive(1'b0, 1'b1, 2'b11, 8'hFF);
        exp_q.push_back(8'hFF);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (Q !== e) begin
            tests_failed++;
            $display("FAIL prio_release: Q=%h expected %h", Q, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m;
        logic [7:0] e;
        logic [7:0] rd;
        logic [1:0] rs;
        logic       rc;
        logic       rn;
        m = 8'h00;
        drive(1'b1, 1'b1, 2'b00, 8'h00);
        tick();
        for (int i = 0; i < 60; i++) begin
            rs = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            rc = ($urandom_range(0, 19) == 0);
            rn = ($urandom_range(0, 14) != 0);
            drive(rc, rn, rs, rd);
            if (rc || !rn)        m = 8'h00;
            else if (rs == 2'b01) m = {ROT ? m[0] : 1'b0, m[7:1]};
            else if (rs == 2'b10) m = {m[6:0], ROT ? m[7] : 1'b0};
            else if (rs == 2'b11) m = rd;
            exp_q.push_back(m);
            tick();
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rand_queue_empty: step %0d", i);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (Q !== e) begin
                    tests_failed++;
                    $display("FAIL rand%0d: Q=%h expected %h mode=%b", i, Q, e, rs);
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b1, 2'b00, 8'h00);
        test_reset();
        test_shift_right();
        test_shift_left();
        test_hold_clear();
        test_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
